rom_loader: RTL

Instruction-memory responder for the CPU's fetch port: answers `pc` with `instruction` from an internal word array. The array is filled at boot from a byte stream, e.g. a UART receiver. The CPU is held in reset until a complete, valid program image has been written. The block sits beside the CPU and drives the CPU's `rst` through `cpu_rst`.

---
 rtl/rom_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: fills an instruction ROM from a boot byte stream and holds the CPU in reset until loaded.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module rom_loader #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_error
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [16:0] MAX_WORDS = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CHECK   = 3'd4,
`endif
    S_RUN     = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t              r_state;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_len;
  logic [7:0]          r_hi;
  logic [ADDR_W-1:0]   r_addr;
  logic [16:0]         r_wcnt;
  logic                r_cpu_rst;
  logic                r_load_done;
  logic                r_load_error;
  logic [15:0]         r_mem [DEPTH];
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic        w_accept;
  logic        w_mem_we;
  logic        w_pc_oob;
  logic [15:0] w_len_new;
  logic [16:0] w_wcnt_nxt;

  assign rx_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_DATA_HI) || (r_state == S_DATA_LO)
`ifdef ROM_LOADER_CHECKSUM_EN
                    || (r_state == S_CHECK)
`endif
                    ;

  assign w_accept   = rx_valid && rx_ready;
  assign w_mem_we   = w_accept && (r_state == S_DATA_LO);
  assign w_len_new  = {r_len_hi, rx_data};
  assign w_wcnt_nxt = r_wcnt + 17'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LEN_HI;
      r_len_hi     <= 8'h00;
      r_len        <= 16'h0000;
      r_hi         <= 8'h00;
      r_addr       <= '0;
      r_wcnt       <= 17'd0;
      r_cpu_rst    <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
      if (w_accept && (r_state != S_CHECK)) r_csum <= r_csum ^ rx_data;
`endif
      unique case (r_state)
        S_LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= rx_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len  <= w_len_new;
            r_addr <= '0;
            r_wcnt <= 17'd0;
            if ({1'b0, w_len_new} > MAX_WORDS) begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end else if (w_len_new == 16'h0000) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              r_state     <= S_CHECK;
`else
              r_state     <= S_RUN;
              r_cpu_rst   <= 1'b0;
              r_load_done <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_hi    <= rx_data;
            r_state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            // a full-size image wraps addr to 0 here, but the state leaves on this edge
            r_addr <= r_addr + ADDR_W'(1);
            r_wcnt <= w_wcnt_nxt;
            if (w_wcnt_nxt == {1'b0, r_len}) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              r_state     <= S_CHECK;
`else
              r_state     <= S_RUN;
              r_cpu_rst   <= 1'b0;
              r_load_done <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            if (rx_data == r_csum) begin
              r_state     <= S_RUN;
              r_cpu_rst   <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end
`endif
        S_RUN, S_ERROR: begin
          if (reload) begin
            r_state      <= S_LEN_HI;
            r_cpu_rst    <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
          end
        end
        default: r_state <= S_LEN_HI;
      endcase
    end
  end

  // Array contents are deliberately not reset; unloaded words keep old data.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= {r_hi, rx_data};
  end

  assign w_pc_oob    = (({16'h0000, pc} >> ADDR_W) != 32'h0);
  assign instruction = w_pc_oob ? 16'h0000 : r_mem[pc[ADDR_W-1:0]];

  assign cpu_rst    = r_cpu_rst;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule
